// File: rtl/oflow_iou_dispatcher.sv
// Initiator side of the IoU calculator link: walks the history buffer, issues one
// calculator transaction per entry and reports the lowest-score (best) history index.
module oflow_iou_dispatcher #(
  parameter int COORD_W = 11,
  parameter int DIM_W   = 11,
  parameter int IOU_W   = 22,
  parameter int HIST_N  = 8,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 reset_N,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4*COORD_W-1:0] req_bbox,
  input  logic [DIM_W-1:0]     req_w,
  input  logic [DIM_W-1:0]     req_h,
  input  logic [IDX_W:0]       req_hist_count,
  input  logic [IOU_W-1:0]     req_thresh,
  output logic                 hist_rd_en,
  output logic [IDX_W-1:0]     hist_rd_addr,
  input  logic [4*COORD_W-1:0] hist_rd_bbox,
  input  logic [DIM_W-1:0]     hist_rd_w,
  input  logic [DIM_W-1:0]     hist_rd_h,
  output logic                 iou_start,
  output logic [4*COORD_W-1:0] iou_bbox_k,
  output logic [DIM_W-1:0]     iou_w_k,
  output logic [DIM_W-1:0]     iou_h_k,
  output logic [4*COORD_W-1:0] iou_bbox_hist,
  output logic [DIM_W-1:0]     iou_w_hist,
  output logic [DIM_W-1:0]     iou_h_hist,
  input  logic                 iou_valid,
  input  logic [IOU_W-1:0]     iou_in,
  output logic                 best_valid,
  output logic [IDX_W-1:0]     best_idx,
  output logic [IOU_W-1:0]     best_iou,
  output logic                 match_found,
  output logic                 err_timeout
);

  localparam int BOX_W  = 4*COORD_W;
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IOU_W-1:0] IOU_MAX = {IOU_W{1'b1}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [IDX_W:0]    idx_q, idx_d;
  logic [IDX_W:0]    count_q, count_d;
  logic [IOU_W-1:0]  thresh_q, thresh_d;
  logic [BOX_W-1:0]  bbox_k_q, bbox_k_d;
  logic [DIM_W-1:0]  w_k_q, w_k_d, h_k_q, h_k_d;
  logic [BOX_W-1:0]  bbox_hist_q, bbox_hist_d;
  logic [DIM_W-1:0]  w_hist_q, w_hist_d, h_hist_q, h_hist_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [IOU_W-1:0]  score_q, score_d;
  logic [IOU_W-1:0]  run_best_q, run_best_d;
  logic [IDX_W-1:0]  run_idx_q, run_idx_d;
  logic              best_valid_q, best_valid_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic [IOU_W-1:0]  best_iou_q, best_iou_d;
  logic              match_q, match_d;
  logic              err_q, err_d;

  logic [IDX_W:0]    idx_inc;
  logic [IDX_W:0]    count_clamped;

  assign idx_inc       = idx_q + 1'b1;
  assign count_clamped = (req_hist_count > (IDX_W+1)'(HIST_N)) ? (IDX_W+1)'(HIST_N)
                                                               : req_hist_count;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    count_d      = count_q;
    thresh_d     = thresh_q;
    bbox_k_d     = bbox_k_q;
    w_k_d        = w_k_q;
    h_k_d        = h_k_q;
    bbox_hist_d  = bbox_hist_q;
    w_hist_d     = w_hist_q;
    h_hist_d     = h_hist_q;
    wcnt_d       = wcnt_q;
    score_d      = score_q;
    run_best_d   = run_best_q;
    run_idx_d    = run_idx_q;
    best_valid_d = 1'b0;
    best_idx_d   = best_idx_q;
    best_iou_d   = best_iou_q;
    match_d      = match_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          thresh_d   = req_thresh;
          bbox_k_d   = req_bbox;
          w_k_d      = req_w;
          h_k_d      = req_h;
          count_d    = count_clamped;
          idx_d      = '0;
          run_best_d = IOU_MAX;
          run_idx_d  = '0;
          state_d    = (count_clamped == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        bbox_hist_d = hist_rd_bbox;
        w_hist_d    = hist_rd_w;
        h_hist_d    = hist_rd_h;
        state_d     = S_START;
      end
      S_START: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wcnt_d = wcnt_q + 1'b1;
        // A result landing on the expiry cycle still counts as a real answer.
        if (iou_valid) begin
          score_d = iou_in;
          state_d = S_NEXT;
        end else if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
          score_d = IOU_MAX;
          err_d   = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (score_q < run_best_q) begin
          run_best_d = score_q;
          run_idx_d  = idx_q[IDX_W-1:0];
        end
        idx_d   = idx_inc;
        state_d = (idx_inc < count_q) ? S_FETCH : S_DONE;
      end
      S_DONE: begin
        best_valid_d = 1'b1;
        best_idx_d   = run_idx_q;
        best_iou_d   = run_best_q;
        match_d      = (run_best_q <= thresh_q);
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      count_q      <= '0;
      thresh_q     <= '0;
      bbox_k_q     <= '0;
      w_k_q        <= '0;
      h_k_q        <= '0;
      bbox_hist_q  <= '0;
      w_hist_q     <= '0;
      h_hist_q     <= '0;
      wcnt_q       <= '0;
      score_q      <= '0;
      run_best_q   <= IOU_MAX;
      run_idx_q    <= '0;
      best_valid_q <= 1'b0;
      best_idx_q   <= '0;
      best_iou_q   <= IOU_MAX;
      match_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      thresh_q     <= thresh_d;
      bbox_k_q     <= bbox_k_d;
      w_k_q        <= w_k_d;
      h_k_q        <= h_k_d;
      bbox_hist_q  <= bbox_hist_d;
      w_hist_q     <= w_hist_d;
      h_hist_q     <= h_hist_d;
      wcnt_q       <= wcnt_d;
      score_q      <= score_d;
      run_best_q   <= run_best_d;
      run_idx_q    <= run_idx_d;
      best_valid_q <= best_valid_d;
      best_idx_q   <= best_idx_d;
      best_iou_q   <= best_iou_d;
      match_q      <= match_d;
      err_q        <= err_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign hist_rd_en    = (state_q == S_FETCH);
  assign hist_rd_addr  = idx_q[IDX_W-1:0];
  assign iou_start     = (state_q == S_START);
  assign iou_bbox_k    = bbox_k_q;
  assign iou_w_k       = w_k_q;
  assign iou_h_k       = h_k_q;
  assign iou_bbox_hist = bbox_hist_q;
  assign iou_w_hist    = w_hist_q;
  assign iou_h_hist    = h_hist_q;
  assign best_valid    = best_valid_q;
  assign best_idx      = best_idx_q;
  assign best_iou      = best_iou_q;
  assign match_found   = match_q;
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_oflow_iou_dispatcher.sv
// Directed bench for oflow_iou_dispatcher: history-buffer and calculator models plus a
// per-cycle comparison against a schedule/argmin model derived from the request.
module tb_oflow_iou_dispatcher;

  localparam int TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        reset_N;
  logic        req_valid;
  logic        req_ready;
  logic [43:0] req_bbox;
  logic [10:0] req_w, req_h;
  logic [3:0]  req_hist_count;
  logic [21:0] req_thresh;
  logic        hist_rd_en;
  logic [2:0]  hist_rd_addr;
  logic [43:0] hist_rd_bbox;
  logic [10:0] hist_rd_w, hist_rd_h;
  logic        iou_start;
  logic [43:0] iou_bbox_k, iou_bbox_hist;
  logic [10:0] iou_w_k, iou_h_k, iou_w_hist, iou_h_hist;
  logic        iou_valid;
  logic [21:0] iou_in;
  logic        best_valid;
  logic [2:0]  best_idx;
  logic [21:0] best_iou;
  logic        match_found;
  logic        err_timeout;

  oflow_iou_dispatcher dut (
    .clk(clk), .reset_N(reset_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_bbox(req_bbox),
    .req_w(req_w), .req_h(req_h), .req_hist_count(req_hist_count), .req_thresh(req_thresh),
    .hist_rd_en(hist_rd_en), .hist_rd_addr(hist_rd_addr), .hist_rd_bbox(hist_rd_bbox),
    .hist_rd_w(hist_rd_w), .hist_rd_h(hist_rd_h),
    .iou_start(iou_start), .iou_bbox_k(iou_bbox_k), .iou_w_k(iou_w_k), .iou_h_k(iou_h_k),
    .iou_bbox_hist(iou_bbox_hist), .iou_w_hist(iou_w_hist), .iou_h_hist(iou_h_hist),
    .iou_valid(iou_valid), .iou_in(iou_in),
    .best_valid(best_valid), .best_idx(best_idx), .best_iou(best_iou),
    .match_found(match_found), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // History buffer contents and calculator script (written by the main sequence only)
  logic [43:0] mem_bbox [8];
  logic [10:0] mem_w [8];
  logic [10:0] mem_h [8];
  logic [21:0] score_tab [16];
  bit          noans [16];
  int          lat_calc;

  // History buffer: one-cycle registered read
  always @(posedge clk) begin
    if (hist_rd_en) begin
      hist_rd_bbox <= mem_bbox[hist_rd_addr];
      hist_rd_w    <= mem_w[hist_rd_addr];
      hist_rd_h    <= mem_h[hist_rd_addr];
    end
  end

  // Calculator: answers pair k lat_calc cycles after its start pulse, unless scripted silent
  initial begin
    int rk;
    int k;
    rk = 0;
    iou_valid = 1'b0;
    iou_in = '0;
    forever begin
      @(negedge clk);
      if (req_valid && req_ready) rk = 0;
      if (iou_start) begin
        k = rk;
        rk++;
        if (!noans[k]) begin
          repeat (lat_calc) @(posedge clk);
          #1 iou_valid = 1'b1;
          iou_in = score_tab[k];
          @(posedge clk);
          #1 iou_valid = 1'b0;
        end
      end
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  // Model state for the transaction in flight
  int          start_at [16];
  int          n_start;
  int          exp_lat;
  logic [21:0] exp_best;
  int          exp_idx;
  bit          exp_match;
  bit          exp_err;
  logic [43:0] cur_bbox;
  logic [10:0] cur_w, cur_h;
  int          starts_seen;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Builds the expected schedule and result from the request, then presents it
  task automatic launch(input int cnt, input logic [21:0] th, input int l);
    int eff;
    int t;
    logic [21:0] sc;
    lat_calc = l;
    eff = (cnt > 8) ? 8 : cnt;
    exp_best = '1;
    exp_idx = 0;
    t = 3;
    for (int k = 0; k < eff; k++) begin
      start_at[k] = t;
      sc = noans[k] ? 22'h3FFFFF : score_tab[k];
      if (sc < exp_best) begin
        exp_best = sc;
        exp_idx = k;
      end
      if (noans[k]) exp_err = 1'b1;
      t += 4 + (noans[k] ? TIMEOUT : l);
    end
    n_start = eff;
    exp_lat = t - 1;
    exp_match = (exp_best <= th);
    cur_bbox = {12'($urandom), 32'($urandom)};
    cur_w = 11'($urandom);
    cur_h = 11'($urandom);
    req_bbox = cur_bbox;
    req_w = cur_w;
    req_h = cur_h;
    req_hist_count = 4'(cnt);
    req_thresh = th;
    req_valid = 1'b1;
    starts_seen = 0;
  endtask

  task automatic compare(input int c);
    bit es, er;
    int ks, kr;
    es = 0; er = 0; ks = 0; kr = 0;
    for (int k = 0; k < n_start; k++) begin
      if (c == start_at[k])     begin es = 1; ks = k; end
      if (c == start_at[k] - 2) begin er = 1; kr = k; end
    end
    chk("req_ready", 64'(req_ready), 64'(c == 0 || c >= exp_lat));
    chk("iou_start", 64'(iou_start), 64'(es));
    if (iou_start) starts_seen++;
    chk("hist_rd_en", 64'(hist_rd_en), 64'(er));
    if (er) chk("hist_rd_addr", 64'(hist_rd_addr), 64'(kr));
    if (es) begin
      chk("iou_bbox_k", 64'(iou_bbox_k), 64'(cur_bbox));
      chk("iou_w_k", 64'(iou_w_k), 64'(cur_w));
      chk("iou_h_k", 64'(iou_h_k), 64'(cur_h));
      chk("iou_bbox_hist", 64'(iou_bbox_hist), 64'(mem_bbox[ks]));
      chk("iou_w_hist", 64'(iou_w_hist), 64'(mem_w[ks]));
      chk("iou_h_hist", 64'(iou_h_hist), 64'(mem_h[ks]));
    end
    chk("best_valid", 64'(best_valid), 64'(c == exp_lat));
    if (c == exp_lat) begin
      chk("best_idx", 64'(best_idx), 64'(exp_idx));
      chk("best_iou", 64'(best_iou), 64'(exp_best));
      chk("match_found", 64'(match_found), 64'(exp_match));
      chk("err_timeout", 64'(err_timeout), 64'(exp_err));
    end
  endtask

  task automatic step(input int c);
    @(negedge clk);
    compare(c);
    @(posedge clk);
    #1;
    if (c == 0) begin
      req_valid = 1'b0;
      req_bbox = ~cur_bbox;
      req_w = ~cur_w;
      req_h = ~cur_h;
    end
  endtask

  task automatic run_req(input int cnt, input logic [21:0] th, input int l);
    launch(cnt, th, l);
    for (int c = 0; c <= exp_lat + 2; c++) step(c);
    $display("txn count=%0d lat=%0d starts=%0d best_idx=%0d best_iou=%0h match=%0b err=%0b",
             cnt, exp_lat, starts_seen, best_idx, best_iou, match_found, err_timeout);
  endtask

  task automatic clear_script();
    for (int k = 0; k < 16; k++) begin
      score_tab[k] = 22'h3FFFFF;
      noans[k] = 1'b0;
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      mem_bbox[k] = {11'(k + 1), 11'(k + 2), 11'(k + 40), 11'(k + 80)};
      mem_w[k] = 11'(39 + 3 * k);
      mem_h[k] = 11'(78 + 5 * k);
    end
    clear_script();
    lat_calc = 3;
    exp_err = 1'b0;
    reset_N = 1'b1;
    req_valid = 1'b0;
    req_bbox = '0;
    req_w = '0;
    req_h = '0;
    req_hist_count = '0;
    req_thresh = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_best_iou", 64'(best_iou), 64'h3FFFFF);
    chk("rst_best_valid", 64'(best_valid), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    chk("rst_start", 64'(iou_start), 64'd0);
    @(posedge clk);
    #1 reset_N = 1'b0;
    @(posedge clk);
    #1;

    // Three pairs, lowest score in the middle
    clear_script();
    score_tab[0] = 22'h300000; score_tab[1] = 22'h100000; score_tab[2] = 22'h200000;
    run_req(3, 22'h180000, 3);
    chk("t1_idx_lit", 64'(best_idx), 64'd1);
    chk("t1_iou_lit", 64'(best_iou), 64'h100000);
    chk("t1_match_lit", 64'(match_found), 64'd1);
    chk("t1_starts_lit", 64'(starts_seen), 64'd3);

    // Empty history
    clear_script();
    run_req(0, 22'h000000, 3);
    chk("t2_iou_lit", 64'(best_iou), 64'h3FFFFF);
    chk("t2_idx_lit", 64'(best_idx), 64'd0);
    chk("t2_starts_lit", 64'(starts_seen), 64'd0);

    // Tie keeps the lower index; threshold equal to score still matches
    clear_script();
    score_tab[0] = 22'h0AAAAA; score_tab[1] = 22'h0AAAAA;
    run_req(2, 22'h0AAAAA, 1);
    chk("t3_idx_lit", 64'(best_idx), 64'd0);
    chk("t3_match_lit", 64'(match_found), 64'd1);

    // Pair 0 never answered
    clear_script();
    noans[0] = 1'b1;
    score_tab[1] = 22'h123456;
    run_req(2, 22'h000000, 2);
    chk("t4_err_lit", 64'(err_timeout), 64'd1);
    chk("t4_idx_lit", 64'(best_idx), 64'd1);
    chk("t4_iou_lit", 64'(best_iou), 64'h123456);

    // Count above HIST_N is clamped; entries past 7 would have won if read
    clear_script();
    for (int k = 0; k < 8; k++) score_tab[k] = 22'h200000 + 22'(((k * 5 + 3) % 8) * 22'h10000);
    for (int k = 8; k < 16; k++) score_tab[k] = 22'h000000;
    run_req(12, 22'h200000, 2);
    chk("t5_starts_lit", 64'(starts_seen), 64'd8);
    chk("t5_idx_lit", 64'(best_idx), 64'd1);
    chk("t5_iou_lit", 64'(best_iou), 64'h200000);

    // Reset during WAIT of pair 1, then a stray calculator answer arrives while idle
    clear_script();
    score_tab[0] = 22'h050000; score_tab[1] = 22'h040000; score_tab[2] = 22'h030000;
    launch(3, 22'h3FFFFF, 3);
    for (int c = 0; c <= 10; c++) step(c);
    reset_N = 1'b1;
    exp_err = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_err", 64'(err_timeout), 64'd0);
    chk("mid_rst_best_iou", 64'(best_iou), 64'h3FFFFF);
    @(posedge clk);
    #1 reset_N = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("quiet_best_valid", 64'(best_valid), 64'd0);
      chk("quiet_ready", 64'(req_ready), 64'd1);
      chk("quiet_start", 64'(iou_start), 64'd0);
      chk("quiet_rd_en", 64'(hist_rd_en), 64'd0);
    end
    @(posedge clk);
    #1;
    clear_script();
    score_tab[0] = 22'h000001;
    run_req(1, 22'h000000, 1);
    chk("t6_iou_lit", 64'(best_iou), 64'h000001);
    chk("t6_match_lit", 64'(match_found), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/oflow_iou_dispatcher.md
Name: oflow_iou_dispatcher

Overview:
- Initiator side of the IoU calculation interface.
- Accepts one current-frame bbox and a count of history bboxes, then reads each history entry from the history buffer (1-cycle read latency).
- For each entry, drives one start/bbox transaction into the IoU calculator and collects its iou/valid_iou response.
- Tracks the lowest iou score (score = 1 - IoU, so lower is better) and reports the best-matching history index to the matching stage.

Parameters:
COORD_W, 11, width of one coordinate; bbox position = 4*COORD_W packed {X_TL, Y_TL, X_BR, Y_BR}
DIM_W, 11, width of bbox width/height fields
IOU_W, 22, width of iou score (unsigned fraction, all-ones = no overlap)
HIST_N, 8, maximum history entries per frame
IDX_W, 3, history index width, clog2(HIST_N)
TIMEOUT, 32, max cycles in WAIT before a pair is abandoned

Ports:
clk  in  1  clock
reset_N  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_bbox  in  4*COORD_W  current-frame bbox position
req_w  in  DIM_W  current-frame width
req_h  in  DIM_W  current-frame height
req_hist_count  in  IDX_W+1  number of history entries to compare (0..HIST_N)
req_thresh  in  IOU_W  match threshold on score
hist_rd_en  out  1  history read strobe
hist_rd_addr  out  IDX_W  history read address
hist_rd_bbox  in  4*COORD_W  history position, valid 1 cycle after hist_rd_en
hist_rd_w  in  DIM_W  history width
hist_rd_h  in  DIM_W  history height
iou_start  out  1  one-cycle start pulse to the calculator
iou_bbox_k  out  4*COORD_W  held stable from iou_start until iou_valid
iou_w_k  out  DIM_W  held stable
iou_h_k  out  DIM_W  held stable
iou_bbox_hist  out  4*COORD_W  held stable
iou_w_hist  out  DIM_W  held stable
iou_h_hist  out  DIM_W  held stable
iou_valid  in  1  calculator result strobe
iou_in  in  IOU_W  calculator score
best_valid  out  1  one-cycle result pulse
best_idx  out  IDX_W  index of lowest score
best_iou  out  IOU_W  lowest score
match_found  out  1  best_iou <= latched threshold; qualified by best_valid
err_timeout  out  1  sticky; cleared only by reset

Behaviour:
- Reset (reset_N high, async): state IDLE; all outputs 0 except req_ready=1; best_iou = all-ones.
- Handshake: request accepted on the cycle req_valid && req_ready. On accept, latch bbox/w/h/thresh and count = min(req_hist_count, HIST_N). Set idx=0, running best = all-ones, best index = 0.
- State machine:
  - IDLE -> FETCH on accept and count>0.
  - IDLE -> DONE on accept and count==0.
  - FETCH: hist_rd_en=1, hist_rd_addr=idx -> LATCH.
  - LATCH: capture hist_rd_* into the iou_*_hist registers -> START.
  - START: iou_start=1 for exactly one cycle; clear wait counter -> WAIT.
  - WAIT: wait counter increments each cycle.
    - On iou_valid: compare iou_in -> NEXT.
    - If the wait counter reaches TIMEOUT-1 with no iou_valid: set err_timeout, treat the score as all-ones -> NEXT.
  - NEXT: update best only if score < running best (strict; ties keep the lower index). idx++. Go to FETCH if idx < count, else DONE.
  - DONE: best_valid=1 for one cycle with best_idx, best_iou, match_found -> IDLE.
- Per-pair overhead: 4 cycles plus calculator latency. Total latency = 2 + count*(4 + L_calc) cycles from accept to best_valid.
- iou_valid outside WAIT is ignored. An iou_valid arriving in the same cycle as timeout expiry counts as valid (no error).
- No new request is accepted until IDLE; req_ready is low from accept through DONE.
- Reset mid-operation: immediate IDLE; in-flight calculator result is discarded; no best_valid is produced.
- best_* outputs hold their last values until the next DONE.
- All comparisons unsigned. idx counter is IDX_W+1 wide so count=HIST_N terminates correctly.

Test Plan:
- count=3, calculator returns scores 0x300000, 0x100000, 0x200000 -> 3 start pulses; best_idx=1, best_iou=0x100000; match_found=1 with thresh=0x180000.
- count=0 -> best_valid 2 cycles after accept, best_iou=0x3FFFFF, best_idx=0, match_found=0, no iou_start.
- count=2, both scores 0x0AAAAA -> best_idx=0 (tie keeps lower index).
- count=2, calculator never answers pair 0 -> after 32 WAIT cycles err_timeout=1, pair 1 still processed; best_idx=1 if its score < all-ones.
- req_hist_count=12 with HIST_N=8 -> exactly 8 iou_start pulses, addresses 0..7.
- reset_N asserted during WAIT of pair 1 -> req_ready=1 next cycle, no best_valid; a stray iou_valid after reset is ignored.
